// File: rtl/qam_pkg.sv
// Shared widths, default lowpass taps, FSM state type and the round/saturate helper
// for the multi-channel I/Q FIR bank.
package qam_pkg;

   localparam int QAM_CH     = 2;
   localparam int QAM_IN_W   = 18;
   localparam int QAM_COEF_W = 16;
   localparam int QAM_TAPS   = 32;

   // Symmetric 32-tap 1Q15 lowpass (100 MHz, 3.15 MHz pass / 10 MHz stop), tap 0 in the LSBs.
   localparam logic [QAM_TAPS*QAM_COEF_W-1:0] LPF_COEFS = {
      -16'sd40,  -16'sd70,  -16'sd95,  -16'sd100, -16'sd60,  16'sd40,   16'sd230,  16'sd510,
      16'sd880,  16'sd1320, 16'sd1790, 16'sd2000, 16'sd2300, 16'sd2500, 16'sd2600, 16'sd2579,
      16'sd2579, 16'sd2600, 16'sd2500, 16'sd2300, 16'sd2000, 16'sd1790, 16'sd1320, 16'sd880,
      16'sd510,  16'sd230,  16'sd40,   -16'sd60,  -16'sd100, -16'sd95,  -16'sd70,  -16'sd40
   };

   typedef enum logic [1:0] {IDLE, MAC, FIN, HOLD} fir_state_t;

   typedef struct packed {
      logic signed [63:0] value;
      logic               sat;
   } sat_res_t;

   // Round half-up, arithmetic shift, then clamp to a signed field of the given width.
   function automatic sat_res_t sat_round(input logic signed [63:0] acc, input int shift,
                                          input int width);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t res;
      r = acc;
      if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
      r = r >>> shift;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      res.value = r;
      res.sat   = 1'b0;
      if (r > hi) begin
         res.value = hi;
         res.sat   = 1'b1;
      end else if (r < lo) begin
         res.value = lo;
         res.sat   = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/qam_fir_chan.sv
// One FIR channel: delay line, serial MAC over the taps, round/saturate into the output register.
module qam_fir_chan
   import qam_pkg::*;
#(
   parameter int                      IN_W      = QAM_IN_W,
   parameter int                      COEF_W    = QAM_COEF_W,
   parameter int                      TAPS      = QAM_TAPS,
   parameter logic [TAPS*COEF_W-1:0]  COEFS     = LPF_COEFS,
   parameter int                      OUT_SHIFT = 15,
   parameter int                      OUT_W     = 32
) (
   input  logic                        axi_clk,
   input  logic                        axi_rstn,
   input  logic                        clear,
   input  logic                        shift_en,
   input  logic signed [IN_W-1:0]      sample,
   input  logic                        acc_clr,
   input  logic                        mac_en,
   input  logic [$clog2(TAPS)-1:0]     k,
   input  logic                        load_out,
   output logic signed [OUT_W-1:0]     out_data,
   output logic                        out_sat
);

   localparam int PW    = IN_W + COEF_W;
   localparam int ACC_W = IN_W + COEF_W + $clog2(TAPS);

   logic signed [COEF_W-1:0] coef [TAPS];
   logic signed [IN_W-1:0]   taps [TAPS];
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc;
   sat_res_t                 res;

   for (genvar i = 0; i < TAPS; i++) begin : g_coef
      assign coef[i] = COEFS[i*COEF_W +: COEF_W];
   end

   assign prod = PW'(coef[k]) * PW'(taps[k]);
   assign res  = sat_round(64'(acc), OUT_SHIFT, OUT_W);

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      end else if (shift_en) begin
         taps[0] <= sample;
         for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         acc <= '0;
      end else if (clear || acc_clr) begin
         acc <= '0;
      end else if (mac_en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         out_data <= '0;
         out_sat  <= 1'b0;
      end else if (load_out) begin
         out_data <= OUT_W'(res.value);
         out_sat  <= res.sat;
      end
   end

endmodule

// File: rtl/qam_fir_bank.sv
// Multi-channel lowpass FIR bank sharing one FSM, decimation counter and valid/ready handshakes.
//
// state | meaning
// IDLE  | accepting input vectors; counts toward the decimation point
// MAC   | one tap per clock into every channel accumulator
// FIN   | round/saturate; load output if the slot is free, else wait
// HOLD  | result ready, waiting for downstream to drain the current output
module qam_fir_bank
   import qam_pkg::*;
#(
   parameter int                      CH        = QAM_CH,
   parameter int                      IN_W      = QAM_IN_W,
   parameter int                      COEF_W    = QAM_COEF_W,
   parameter int                      TAPS      = QAM_TAPS,
   parameter logic [TAPS*COEF_W-1:0]  COEFS     = LPF_COEFS,
   parameter int                      DECIM     = 1,
   parameter int                      OUT_SHIFT = 15,
   parameter int                      OUT_W     = 32
) (
   input  logic                 axi_clk,
   input  logic                 axi_rstn,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*IN_W-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*OUT_W-1:0]  out_data,
   output logic [CH-1:0]        out_sat
);

   localparam int KW = $clog2(TAPS);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

   fir_state_t    state;
   logic [KW-1:0] k;
   logic [DW-1:0] dcnt;
   logic          rdy_q;
   logic          accept;
   logic          dec_hit;
   logic          load;
   logic          mac_en;

   // rdy_q keeps in_ready low until the first edge after reset release.
   assign in_ready = rdy_q && (state == IDLE);
   assign accept   = in_valid && in_ready && !clear;
   assign dec_hit  = (dcnt == DW'(DECIM - 1));
   assign mac_en   = (state == MAC) && !clear;
   assign load     = !clear && (((state == FIN) && (!out_valid || out_ready)) ||
                                ((state == HOLD) && out_ready));

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state     <= IDLE;
         k         <= '0;
         dcnt      <= '0;
         rdy_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (clear) begin
            state     <= IDLE;
            k         <= '0;
            dcnt      <= '0;
            out_valid <= 1'b0;
         end else begin
            if (accept) dcnt <= dec_hit ? '0 : dcnt + 1'b1;
            if (load)
               out_valid <= 1'b1;
            else if (out_ready)
               out_valid <= 1'b0;
            case (state)
               IDLE: begin
                  if (accept && dec_hit) begin
                     state <= MAC;
                     k     <= '0;
                  end
               end
               MAC: begin
                  k <= k + 1'b1;
                  if (k == KW'(TAPS - 1)) state <= FIN;
               end
               FIN:     state <= load ? IDLE : HOLD;
               HOLD:    if (load) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_chan
      qam_fir_chan #(
         .IN_W      (IN_W),
         .COEF_W    (COEF_W),
         .TAPS      (TAPS),
         .COEFS     (COEFS),
         .OUT_SHIFT (OUT_SHIFT),
         .OUT_W     (OUT_W)
      ) u_chan (
         .axi_clk  (axi_clk),
         .axi_rstn (axi_rstn),
         .clear    (clear),
         .shift_en (accept),
         .sample   (in_data[c*IN_W +: IN_W]),
         .acc_clr  (accept && dec_hit),
         .mac_en   (mac_en),
         .k        (k),
         .load_out (load),
         .out_data (out_data[c*OUT_W +: OUT_W]),
         .out_sat  (out_sat[c])
      );
   end

endmodule

// File: doc/qam_fir_bank.md
Name: qam_fir_bank

Overview:
Parametrised multi-channel lowpass FIR that replaces the vendor-IP I/Q filter pair after the demodulator multiplier. It has one time-multiplexed MAC per channel and shared valid/ready handshakes on input and output. It supports optional decimation, runtime clear, rounding and saturation to a configurable output width. The default configuration (CH=2, I/Q) matches the existing 100 MHz, 3.15 MHz pass / 10 MHz stop lowpass.

Parameters:
CH, 2, number of channels sharing one handshake (ch0 = Q, ch1 = I)
IN_W, 18, input sample width, signed 5Q12
COEF_W, 16, coefficient width, signed 1Q15
TAPS, 32, number of taps, >=2
COEFS, qam_pkg::LPF_COEFS, TAPS-entry signed coefficient array; tap 0 multiplies the newest sample
DECIM, 1, decimation factor, >=1
OUT_SHIFT, 15, arithmetic right shift applied to accumulator before saturation
OUT_W, 32, output sample width, signed

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of delay lines, decimation counter and pending output
in_valid  in  1  input sample vector valid
in_ready  out  1  block accepts input vector
in_data  in  CH*IN_W  packed samples, ch0 in LSBs
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts output
out_data  out  CH*OUT_W  packed filtered samples, ch0 in LSBs
out_sat  out  CH  per-channel saturation flag for the current out_data

Behaviour:
- Reset (axi_rstn=0, async): state=IDLE, delay lines=0, decim counter=0, accumulators=0. Outputs: out_valid=0, out_data=0, out_sat=0, in_ready=0 during reset and 1 from the first edge after release.
- Transfer occurs when valid&&ready is high at a rising edge. An accepted vector shifts into every channel's TAPS-deep delay line (tap0 = newest) and increments the decim counter, which wraps at DECIM-1.
- State machine IDLE -> MAC -> FIN -> (HOLD) -> IDLE:
  - IDLE: in_ready=1. On accept: if the pre-increment counter == DECIM-1, go to MAC with k=0 and acc=0; otherwise stay in IDLE.
  - MAC: in_ready=0. Each cycle acc += COEFS[k]*tap[k], k++. Leave to FIN after k=TAPS-1 (TAPS cycles).
  - FIN: in_ready=0. Apply rounding (add 1<<(OUT_SHIFT-1) when OUT_SHIFT>0), then arithmetic shift right by OUT_SHIFT, then saturate to OUT_W. If out_valid==0 or out_ready==1: load out_data/out_sat, set out_valid=1, go to IDLE. Otherwise go to HOLD.
  - HOLD: in_ready=0. Wait for out_ready, then load and go to IDLE.
- Latency: with out_ready=1, out_valid rises on the edge TAPS+1 clocks after the accepting edge. Maximum throughput is one output per TAPS+2 clocks.
- Output: out_valid drops on the edge where out_ready=1 unless FIN/HOLD loads a new vector on that same edge. out_data and out_sat are stable while out_valid&&!out_ready.
- ACC_W = IN_W+COEF_W+$clog2(TAPS). No accumulator overflow is possible.
- Saturation: shifted value > 2^(OUT_W-1)-1 yields max with out_sat=1. Value < -2^(OUT_W-1) yields min with out_sat=1. Otherwise out_sat=0.
- clear: takes priority over everything in any state. Zeros delay lines and counter, sets out_valid=0 and state=IDLE. An in_valid in the same cycle as clear is not accepted.
- Reset mid-MAC: the result is discarded and no output is produced.
- All channels are computed in lockstep and share one FSM.

Decomposition:
- qam_pkg holds:
  - the default widths
  - the LPF_COEFS localparam (32-tap, 1Q15, 100 MHz design)
  - the typedef enum fir_state_t {IDLE, MAC, FIN, HOLD}
  - a sat_round function (acc, shift, width) returning value and flag
- Sub-module qam_fir_chan: one channel's delay line, MAC and round/saturate. It is instantiated CH times under a generate loop. The FSM, decimation counter and handshake live in the top level.

Test Plan:
1. Impulse: TAPS=4, COEFS={1,2,3,4}, OUT_SHIFT=0, DECIM=1; ch0 in = 1,0,0,0,0 -> out = 1,2,3,4,0. Each out_valid arrives 5 clocks after its accept.
2. Step: same config, ch1 in = 4096 repeated -> out = 4096,12288,24576,40960,40960. ch0 held at 0 outputs 0.
3. Saturation: OUT_W=16, COEFS={32767,...}, in = 131071 -> out = 32767, out_sat=1. in = -131072 -> out = -32768, out_sat=1. in = 0 -> out_sat=0.
4. Decimation: DECIM=2, config from 1, impulse at sample 0 -> out_valid only after samples 1,3,5, with values 2,4,0.
5. Backpressure: hold out_ready=0 across two computations -> first out_data stable, FSM in HOLD, in_ready=0. Raise out_ready for 1 clock -> exactly one transfer, second result loaded on the same edge.
6. clear/reset mid-MAC: assert clear on MAC cycle 2 -> no out_valid, state IDLE next clock, next impulse reproduces scenario 1. Repeat with axi_rstn pulse -> same result.
